// File: rtl/boot_pkg.sv
// Shared state encoding, error codes and a state-decode helper for the
// instruction-memory boot sequencer.
package boot_pkg;

    localparam logic [2:0] ST_HDR0  = 3'd0;
    localparam logic [2:0] ST_HDR1  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_RUN   = 3'd4;
    localparam logic [2:0] ST_HALT  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // Only the frame-parsing states consume bytes from the source.
    function automatic logic accepts_bytes(input logic [2:0] st);
        return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_LOAD) || (st == ST_CSUM);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs four accepted bytes, little-endian, into a registered 32-bit word
// and flags it with a one-cycle word_valid.
module byte_word_packer (
    input  logic        clk,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_full,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    logic [23:0] acc;

    assign word_full = byte_valid && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_cnt   <= 2'd0;
            acc        <= 24'd0;
            word_valid <= 1'b0;
            word_data  <= 32'd0;
        end else begin
            word_valid <= word_full;
            if (byte_valid) begin
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    acc[7:0]   <= byte_data;
                    2'd1:    acc[15:8]  <= byte_data;
                    2'd2:    acc[23:16] <= byte_data;
                    default: word_data  <= {byte_data, acc};
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_boot_sequencer.sv
// Loads instruction memory from a framed byte stream, verifies the XOR
// checksum, then releases the core from reset with an optional run watchdog.
module imem_boot_sequencer
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int RUN_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              boot_done,
    output logic              boot_err,
    output logic              run_timeout,
    output logic [1:0]        err_code
);

    logic [2:0]        state, next_state;
    logic [7:0]        len_lo, csum;
    logic [15:0]       n_words, word_cnt;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       run_cnt;
    logic [1:0]        err_q;
    logic [16:0]       hdr_len;
    logic              xfer, do_restart, load_byte, word_full, word_valid;
    logic [31:0]       word_data;

    assign rx_ready   = !rst && accepts_bytes(state);
    assign xfer       = rx_valid && rx_ready;
    assign do_restart = restart && ((state == ST_RUN) || (state == ST_HALT) || (state == ST_ERROR));
    assign load_byte  = xfer && (state == ST_LOAD);
    assign hdr_len    = {1'b0, rx_data, len_lo};

    byte_word_packer u_packer (
        .clk        (clk),
        .clear      (rst || do_restart),
        .byte_valid (load_byte),
        .byte_data  (rx_data),
        .word_full  (word_full),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_HDR0: if (xfer) next_state = ST_HDR1;
            ST_HDR1: if (xfer) begin
                if (hdr_len > 17'(DEPTH))  next_state = ST_ERROR;
                else if (hdr_len == 17'd0) next_state = ST_CSUM;
                else                       next_state = ST_LOAD;
            end
            ST_LOAD: if (word_full && (word_cnt == n_words - 16'd1)) next_state = ST_CSUM;
            ST_CSUM: if (xfer) next_state = (rx_data == csum) ? ST_RUN : ST_ERROR;
            ST_RUN:  if ((RUN_LIMIT != 0) && (run_cnt == 32'(RUN_LIMIT - 1))) next_state = ST_HALT;
            ST_HALT, ST_ERROR: ;
            default: next_state = ST_HDR0;
        endcase
        if (do_restart) next_state = ST_HDR0;
    end

    // core_rst_n follows the next state so release and re-assert line up with the state edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_HDR0;
            core_rst_n <= 1'b0;
            len_lo     <= 8'd0;
            n_words    <= 16'd0;
            word_cnt   <= 16'd0;
            wr_addr    <= '0;
            csum       <= 8'd0;
            run_cnt    <= 32'd0;
            err_q      <= ERR_NONE;
        end else begin
            state      <= next_state;
            core_rst_n <= (next_state == ST_RUN);
            if (do_restart) begin
                len_lo   <= 8'd0;
                n_words  <= 16'd0;
                word_cnt <= 16'd0;
                wr_addr  <= '0;
                csum     <= 8'd0;
                run_cnt  <= 32'd0;
                err_q    <= ERR_NONE;
            end else begin
                if (xfer && (state == ST_HDR0)) len_lo <= rx_data;
                if (xfer && (state == ST_HDR1)) begin
                    n_words <= hdr_len[15:0];
                    if (hdr_len > 17'(DEPTH)) err_q <= ERR_LEN;
                end
                if (load_byte)  csum     <= csum ^ rx_data;
                if (word_full)  word_cnt <= word_cnt + 16'd1;
                if (word_valid) wr_addr  <= wr_addr + ADDR_W'(1);
                if (xfer && (state == ST_CSUM) && (rx_data != csum)) err_q <= ERR_CSUM;
                if (state == ST_RUN) run_cnt <= run_cnt + 32'd1;
            end
        end
    end

    assign imem_we     = word_valid;
    assign imem_waddr  = wr_addr;
    assign imem_wdata  = word_data;
    assign boot_done   = (state == ST_RUN);
    assign boot_err    = (state == ST_ERROR);
    assign run_timeout = (state == ST_HALT);
    assign err_code    = err_q;

endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Self-checking bench: table of boot frames replayed with random gaps and
// checked against a frame-level model, plus hand-written reset/restart cases.
module tb_imem_boot_sequencer;

    localparam int DEPTH     = 256;
    localparam int RUN_LIMIT = 10;

    logic        clk = 1'b0;
    logic        rst, rx_valid, restart;
    logic [7:0]  rx_data;
    logic        rx_ready, imem_we, core_rst_n, boot_done, boot_err, run_timeout;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic        f_rx_ready, f_imem_we, f_core_rst_n, f_boot_done, f_boot_err, f_run_timeout;
    logic [7:0]  f_imem_waddr;
    logic [31:0] f_imem_wdata;
    logic [1:0]  f_err_code;

    always #5 clk = ~clk;

    imem_boot_sequencer #(.ADDR_W(8), .DEPTH(DEPTH), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .restart(restart), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .boot_done(boot_done), .boot_err(boot_err),
        .run_timeout(run_timeout), .err_code(err_code)
    );

    // Identical stimulus, watchdog disabled: the core must stay released.
    imem_boot_sequencer #(.ADDR_W(8), .DEPTH(DEPTH), .RUN_LIMIT(0)) dut_free (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(f_rx_ready),
        .restart(restart), .imem_we(f_imem_we), .imem_waddr(f_imem_waddr), .imem_wdata(f_imem_wdata),
        .core_rst_n(f_core_rst_n), .boot_done(f_boot_done), .boot_err(f_boot_err),
        .run_timeout(f_run_timeout), .err_code(f_err_code)
    );

    typedef struct {
        int         n;
        bit         rand_payload;
        int         csum_mode;
        logic [7:0] csum_val;
        logic [1:0] exp_code;
        int         max_gap;
    } vec_t;

    vec_t        vecs[7];
    logic [7:0]  fixed_pl[8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0]  pl[$];
    logic [39:0] wq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur_gap = 0;

    always @(negedge clk) if (imem_we === 1'b1) wq.push_back({imem_waddr, imem_wdata});

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        bit ok = 0;
        rx_valid = 1'b0;
        repeat ($urandom_range(0, cur_gap)) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 20; i++) begin
            if (rx_ready === 1'b1) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        if (!ok) checkOutput("handshake", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0] x, c;
        pl.delete();
        x = 8'h00;
        cur_gap = v.max_gap;
        if (v.n <= DEPTH) begin
            for (int k = 0; k < 4 * v.n; k++) begin
                if (v.rand_payload || k >= 8) pl.push_back(8'($urandom));
                else pl.push_back(fixed_pl[k]);
                x ^= pl[k];
            end
        end
        c = (v.csum_mode == 0) ? x : (v.csum_mode == 1) ? v.csum_val : (x ^ 8'h01);
        sendByte(v.n[7:0]);
        sendByte(v.n[15:8]);
        if (v.n > DEPTH) return;
        foreach (pl[k]) sendByte(pl[k]);
        sendByte(c);
    endtask

    task automatic pulseRestart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic runVector(input int idx);
        int exp_n, hi;
        logic [31:0] exp_word;
        wq.delete();
        applyStimulus(vecs[idx]);
        exp_n = (vecs[idx].n <= DEPTH) ? vecs[idx].n : 0;
        checkOutput($sformatf("v%0d_wr_count", idx), wq.size(), exp_n);
        for (int k = 0; k < exp_n && k < wq.size(); k++) begin
            exp_word = {pl[4*k+3], pl[4*k+2], pl[4*k+1], pl[4*k]};
            checkOutput($sformatf("v%0d_waddr%0d", idx, k), 32'(wq[k][39:32]), k);
            checkOutput($sformatf("v%0d_wdata%0d", idx, k), wq[k][31:0], exp_word);
        end
        checkOutput($sformatf("v%0d_err_code", idx), err_code, vecs[idx].exp_code);
        if (vecs[idx].exp_code == 2'd0) begin
            checkOutput($sformatf("v%0d_boot_done", idx), boot_done, 1);
            checkOutput($sformatf("v%0d_rx_ready_run", idx), rx_ready, 0);
            hi = 0;
            for (int i = 0; i < 100; i++) begin
                if (core_rst_n !== 1'b1) break;
                hi++;
                @(negedge clk);
            end
            checkOutput($sformatf("v%0d_run_cycles", idx), hi, RUN_LIMIT);
            checkOutput($sformatf("v%0d_run_timeout", idx), run_timeout, 1);
            checkOutput($sformatf("v%0d_halt_core_rst_n", idx), core_rst_n, 0);
            checkOutput($sformatf("v%0d_free_core_rst_n", idx), f_core_rst_n, 1);
        end else begin
            checkOutput($sformatf("v%0d_boot_err", idx), boot_err, 1);
            checkOutput($sformatf("v%0d_err_core_rst_n", idx), core_rst_n, 0);
            checkOutput($sformatf("v%0d_err_rx_ready", idx), rx_ready, 0);
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            @(negedge clk);
            rx_valid = 1'b0;
            checkOutput($sformatf("v%0d_err_hold", idx), {boot_err, err_code}, {1'b1, vecs[idx].exp_code});
            checkOutput($sformatf("v%0d_no_late_we", idx), wq.size(), exp_n);
        end
        pulseRestart();
        checkOutput($sformatf("v%0d_restart_state", idx),
                    {rx_ready, boot_done, boot_err, run_timeout, core_rst_n, err_code},
                    {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0});
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] b[5];
        vecs[0] = '{2,   1'b0, 0, 8'h00, 2'd0, 0};
        vecs[1] = '{2,   1'b0, 1, 8'h00, 2'd2, 1};
        vecs[2] = '{5,   1'b1, 0, 8'h00, 2'd0, 3};
        vecs[3] = '{257, 1'b0, 1, 8'h00, 2'd1, 1};
        vecs[4] = '{0,   1'b0, 1, 8'h00, 2'd0, 0};
        vecs[5] = '{0,   1'b0, 1, 8'h01, 2'd2, 2};
        vecs[6] = '{3,   1'b1, 2, 8'h00, 2'd2, 2};

        rst = 1'b1; rx_valid = 1'b0; restart = 1'b0; rx_data = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs",
                    {rx_ready, imem_we, core_rst_n, boot_done, boot_err, run_timeout, err_code},
                    8'd0);
        checkOutput("reset_wdata", {imem_waddr, imem_wdata}, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_rx_ready", rx_ready, 1);

        for (int i = 0; i < 7; i++) runVector(i);

        // Restart is ignored mid-load; rst aborts the load with no extra write.
        cur_gap = 2;
        wq.delete();
        for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
        sendByte(8'd4);
        sendByte(8'd0);
        sendByte(b[0]);
        sendByte(b[1]);
        pulseRestart();
        checkOutput("load_restart_ignored", {rx_ready, boot_err}, {1'b1, 1'b0});
        sendByte(b[2]);
        sendByte(b[3]);
        sendByte(b[4]);
        checkOutput("partial_wr_count", wq.size(), 1);
        if (wq.size() > 0) checkOutput("partial_word", wq[0], {8'd0, b[3], b[2], b[1], b[0]});
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midload_rst", {imem_we, rx_ready, core_rst_n}, 3'b000);
        rst = 1'b0;
        wq.delete();
        repeat (4) @(negedge clk);
        checkOutput("no_spurious_we", wq.size(), 0);
        checkOutput("rst_back_hdr0", {rx_ready, boot_done, boot_err}, 3'b100);
        runVector(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
